// File: rtl/row_serializer.sv
// rtl/row_serializer.sv - ten-word row capture and word-per-cycle valid/ready serializer
// Optional feature macro: ROWSER_B2B_EN (capture the next row on the final-transfer edge)
module row_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] Din1,
    input  logic [WIDTH-1:0] Din2,
    input  logic [WIDTH-1:0] Din3,
    input  logic [WIDTH-1:0] Din4,
    input  logic [WIDTH-1:0] Din5,
    input  logic [WIDTH-1:0] Din6,
    input  logic [WIDTH-1:0] Din7,
    input  logic [WIDTH-1:0] Din8,
    input  logic [WIDTH-1:0] Din9,
    input  logic [WIDTH-1:0] Din10,
    input  logic             rdy,
    output logic [WIDTH-1:0] Dout,
    output logic [3:0]       idx,
    output logic             vld,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shadow [10];
    logic             xfer;
    logic             last;
    logic             load;
    logic             reload;

    // vld and busy are both exactly "row held", so they come straight from the state bit
    assign vld  = (state == SEND);
    assign busy = (state == SEND);
    assign Dout = vld ? shadow[idx] : '0;

    always_ff @(negedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        xfer       = 1'b0;
        last       = 1'b0;
        reload     = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (ld) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                xfer = rdy;
                last = rdy && (idx == 4'd9);
`ifdef ROWSER_B2B_EN
                reload = last && ld;
`else
                reload = 1'b0;
`endif
                load = reload;
                if (last && !reload) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge CLK or negedge reset) begin
        if (!reset) begin
            idx  <= 4'd0;
            done <= 1'b0;
            for (int i = 0; i < 10; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            done <= last;
            if (load) begin
                shadow[0] <= Din1;
                shadow[1] <= Din2;
                shadow[2] <= Din3;
                shadow[3] <= Din4;
                shadow[4] <= Din5;
                shadow[5] <= Din6;
                shadow[6] <= Din7;
                shadow[7] <= Din8;
                shadow[8] <= Din9;
                shadow[9] <= Din10;
            end
            if (load || last) begin
                idx <= 4'd0;
            end else if (xfer) begin
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_row_serializer.sv
// tb/tb_row_serializer.sv - scoreboard bench for row_serializer (falling-edge DUT, sampled after rising edge)
module tb_row_serializer;

    logic        CLK;
    logic        reset;
    logic        ld;
    logic        rdy;
    logic [15:0] din [10];
    logic [15:0] Dout;
    logic [3:0]  idx;
    logic        vld;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_fails;
    int          done_count;
    logic [19:0] exp_q [$];
    bit          expect_done;
    int          k;
`ifdef ROWSER_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    row_serializer #(.WIDTH(16)) dut (
        .CLK(CLK), .reset(reset), .ld(ld),
        .Din1(din[0]), .Din2(din[1]), .Din3(din[2]), .Din4(din[3]), .Din5(din[4]),
        .Din6(din[5]), .Din7(din[6]), .Din8(din[7]), .Din9(din[8]), .Din10(din[9]),
        .rdy(rdy), .Dout(Dout), .idx(idx), .vld(vld), .busy(busy), .done(done)
    );

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every transfer is popped and compared against the scoreboard
    initial begin
        expect_done = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (!reset) begin
                expect_done = 1'b0;
            end else begin
                if (expect_done) begin
                    check("done_pulse", {31'd0, done}, 32'd1);
                    expect_done = 1'b0;
                end else if (done) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end
                if (done) done_count++;
                if (!B2B && vld && done) check("vld_done_overlap", 32'd1, 32'd0);
                if (vld && rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {12'd0, idx, Dout}, 32'hFFFF_FFFF);
                    end else begin
                        logic [19:0] e;
                        e = exp_q.pop_front();
                        check("word_idx", {28'd0, idx}, {28'd0, e[19:16]});
                        check("word_data", {16'd0, Dout}, {16'd0, e[15:0]});
                        if (e[19:16] == 4'd9) expect_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
    endtask

    task automatic load_row(input logic [15:0] base, input bit push);
        for (int i = 0; i < 10; i++) begin
            din[i] = base + 16'(i);
            if (push) exp_q.push_back({4'(i), base + 16'(i)});
        end
        ld = 1'b1;
    endtask

    // mode 0: rdy high; 1: rdy 1,0,0 pattern; 2: 20-cycle stall at idx 3;
    // 3: Din change + ld during SEND; 4: ld on final-transfer edge; 5: reset at idx 5
    task automatic run(input int mode, output int cycles);
        cycles = 0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            ld = 1'b0;
            cycles = c;
            case (mode)
                1: rdy = ((c - 1) % 3 == 0);
                2: rdy = !(c >= 4 && c <= 23);
                default: rdy = 1'b1;
            endcase
            if (mode == 3 && c == 3) begin
                for (int i = 0; i < 10; i++) din[i] = 16'h5555;
                ld = 1'b1;
            end
            if (mode == 4 && c == 10) load_row(16'h0100, B2B);
            #1;
            if (mode == 2 && c >= 4 && c <= 23) begin
                check("stall_data", {16'd0, Dout}, 32'h0004);
                check("stall_idx", {28'd0, idx}, 32'd3);
            end
            if (mode == 5 && c == 6) begin
                check("pre_reset_idx", {28'd0, idx}, 32'd5);
                #2;
                reset = 1'b0;
                #1;
                check("areset_vld", {31'd0, vld}, 32'd0);
                check("areset_busy", {31'd0, busy}, 32'd0);
                check("areset_done", {31'd0, done}, 32'd0);
                check("areset_idx", {28'd0, idx}, 32'd0);
                check("areset_dout", {16'd0, Dout}, 32'd0);
                exp_q.delete();
                return;
            end
            if (done) return;
        end
        check("timeout_waiting_done", 32'd0, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fails = 0;
        done_count = 0;
        reset = 1'b0;
        ld = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) din[i] = '0;
        #12;
        check("rst_vld", {31'd0, vld}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_idx", {28'd0, idx}, 32'd0);
        check("rst_dout", {16'd0, Dout}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // basic row
        load_row(16'h0001, 1'b1);
        run(0, k);
        check("basic_cycles", k, 32'd11);
        tick();
        #1;
        check("basic_busy_after", {31'd0, busy}, 32'd0);
        check("basic_vld_after", {31'd0, vld}, 32'd0);
        check("basic_q_empty", exp_q.size(), 32'd0);

        // backpressure pattern 1,0,0
        tick();
        load_row(16'h0001, 1'b1);
        run(1, k);
        check("bp_cycles", k, 32'd29);
        tick();
        check("bp_q_empty", exp_q.size(), 32'd0);

        // long stall at idx 3
        load_row(16'h0001, 1'b1);
        run(2, k);
        check("stall_cycles", k, 32'd31);
        tick();
        check("stall_q_empty", exp_q.size(), 32'd0);

        // Din isolation
        for (int i = 0; i < 10; i++) din[i] = 16'hAAAA;
        ld = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back({4'(i), 16'hAAAA});
        run(3, k);
        check("iso_cycles", k, 32'd11);
        tick();
        tick();
        tick();
        #1;
        check("iso_no_second_row", {31'd0, busy}, 32'd0);
        check("iso_q_empty", exp_q.size(), 32'd0);

        // reset mid-row
        load_row(16'h0001, 1'b1);
        run(5, k);
        tick();
        tick();
        reset = 1'b1;
        done_count = 0;
        for (int c = 0; c < 15; c++) tick();
        #1;
        check("post_reset_done_count", done_count, 32'd0);
        check("post_reset_busy", {31'd0, busy}, 32'd0);

        // back-to-back
        tick();
        done_count = 0;
        load_row(16'h0001, 1'b1);
        run(4, k);
        check("b2b_first_cycles", k, 32'd11);
        if (B2B) begin
            check("b2b_vld_at_done", {31'd0, vld}, 32'd1);
            check("b2b_dout_at_done", {16'd0, Dout}, 32'h0100);
            ld = 1'b0;
            run(0, k);
            check("b2b_second_cycles", k, 32'd10);
            check("b2b_done_count", done_count, 32'd2);
        end else begin
            tick();
            ld = 1'b0;
            #1;
            check("nob2b_busy", {31'd0, busy}, 32'd0);
            check("nob2b_vld", {31'd0, vld}, 32'd0);
            tick();
            check("nob2b_done_count", done_count, 32'd1);
        end
        tick();
        tick();
        check("final_q_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
